// File: rtl/siso_pkg.sv
// Shared types and default sizing for the serial-in/serial-out shift controller.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/siso_track_pipe.sv
// Valid and last-bit shadow pipelines that follow serial bits through the
// downstream DEPTH-stage shift register.
module siso_track_pipe
    import siso_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    input  logic last_in,
    output logic q_valid,
    output logic q_last,
    output logic empty_next
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] l_q, l_d;

    always_comb begin
        v_d    = '0;
        l_d    = '0;
        v_d[0] = valid_in;
        l_d[0] = last_in;
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i] = v_q[i-1];
            l_d[i] = l_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            l_q <= '0;
        end else begin
            v_q <= v_d;
            l_q <= l_d;
        end
    end

    assign q_valid    = v_q[DEPTH-1];
    assign q_last     = l_q[DEPTH-1];
    // Lets FLUSH leave on the same edge that shifts the final valid bit out.
    assign empty_next = ~|v_d;

endmodule

// File: rtl/siso_shift_ctrl.sv
// Serializes parallel words into a downstream SISO register and tracks which
// bits on its Q output are valid and which one ends a word.
module siso_shift_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             msb_first,
    output logic             ser_in,
    output logic             q_valid,
    output logic             word_done,
    output logic             busy,
    output state_t           state_dbg
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: a word transfers on the rising edge where in_valid && in_ready;
    // in_valid without in_ready does nothing and in_data may change freely.

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d, data_sh;
    logic             msb_q, msb_d;
    logic             ser_q, ser_d;
    logic             accept, shifting, last_bit;
    logic             pipe_last, pipe_empty_next;

    assign shifting = (state_q == SHIFT);
    assign last_bit = shifting && (cnt_q == '0);
    assign in_ready = !shifting || last_bit;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        msb_d   = msb_q;
        ser_d   = 1'b0;
        data_sh = msb_q ? (data_q << 1) : (data_q >> 1);
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = CW'(WIDTH - 1);
            data_d  = in_data;
            msb_d   = msb_first;
            ser_d   = msb_first ? in_data[WIDTH-1] : in_data[0];
        end else begin
            case (state_q)
                SHIFT: begin
                    if (last_bit) begin
                        state_d = FLUSH;
                    end else begin
                        cnt_d  = cnt_q - CW'(1);
                        data_d = data_sh;
                        ser_d  = msb_q ? data_sh[WIDTH-1] : data_sh[0];
                    end
                end
                FLUSH: begin
                    if (pipe_empty_next) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            msb_q   <= 1'b0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            msb_q   <= msb_d;
            ser_q   <= ser_d;
        end
    end

    // The pipe input is the registered ser_in's validity, so it lines up with ser_in.
    siso_track_pipe #(.DEPTH(DEPTH)) u_track (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (shifting),
        .last_in    (last_bit),
        .q_valid    (q_valid),
        .q_last     (pipe_last),
        .empty_next (pipe_empty_next)
    );

    assign ser_in    = ser_q;
    assign word_done = q_valid && pipe_last;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Self-checking bench: a cycle timeline model schedules each accepted word's bits
// and derives every output per cycle from that schedule.
module tb_siso_shift_ctrl;
  import siso_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int NC = 4096;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic msb_first = 1'b0;
  logic in_ready, ser_in, q_valid, word_done, busy;
  state_t state_dbg;

  always #5 clk = ~clk;

  siso_shift_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msb_first (msb_first),
    .ser_in    (ser_in),
    .q_valid   (q_valid),
    .word_done (word_done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int end_cyc = -1;
  bit known = 1'b0;
  bit exp_ser[NC];
  bit exp_dv[NC];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit busy_model(input int c);
    for (int k = c - D; k <= c; k++)
      if (k >= 0 && exp_dv[k]) return 1'b1;
    return 1'b0;
  endfunction

  // driver: check the current cycle, apply inputs, then advance the model
  task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic m);
    bit rdy, qv, wd, bz;
    @(negedge clk);
    rdy = (end_cyc <= cyc);
    qv  = (cyc >= D) ? exp_dv[cyc-D] : 1'b0;
    bz  = busy_model(cyc);
    wd  = (exp_q.size() > 0) && (exp_q[0] == cyc);
    if (wd) void'(exp_q.pop_front());
    if (known) begin
      check("ser_in",    32'(ser_in),    32'(exp_ser[cyc]));
      check("q_valid",   32'(q_valid),   32'(qv));
      check("word_done", 32'(word_done), 32'(wd));
      check("busy",      32'(busy),      32'(bz));
      check("in_ready",  32'(in_ready),  32'(rdy));
      check("state_act", 32'(state_dbg != IDLE), 32'(bz));
    end
    rst = r; in_valid = v; in_data = d; msb_first = m;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NC; i++) begin
        exp_ser[i] = 1'b0;
        exp_dv[i]  = 1'b0;
      end
      exp_q.delete();
      end_cyc = cyc;
      known = 1'b1;
    end else if (v && rdy) begin
      if (cyc + W + 1 >= NC) begin
        $display("FAIL model_range cycle=%0d got=%0d exp<%0d", cyc, cyc + W + 1, NC);
        $fatal(1);
      end
      for (int k = 0; k < W; k++) begin
        exp_dv[cyc+1+k]  = 1'b1;
        exp_ser[cyc+1+k] = d[m ? (W - 1 - k) : k];
      end
      exp_q.push_back(32'(cyc + W + D));
      end_cyc = cyc + W;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom), 1'($urandom));
  endtask

  initial begin
    // reset held for two cycles
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    // single word, LSB first
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    idle(16);
    // back-to-back, MSB first, second offered on the last bit cycle
    step(1'b0, 1'b1, 8'h01, 1'b1);
    idle(7);
    step(1'b0, 1'b1, 8'h80, 1'b1);
    idle(18);
    // stall: in_valid held high with changing data
    for (int i = 0; i < 26; i++) step(1'b0, 1'b1, W'($urandom), 1'($urandom));
    idle(14);
    // mid-operation reset
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    idle(2);
    step(1'b1, 1'b0, '0, 1'b0);
    idle(14);
    // restart from FLUSH
    step(1'b0, 1'b1, 8'hC3, 1'b1);
    idle(9);
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    idle(20);
    // randomized traffic with occasional resets
    for (int i = 0; i < 1200; i++)
      step(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 2) != 0),
           W'($urandom), 1'($urandom));
    idle(16);
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/siso_shift_ctrl.md
SISO_SHIFT_CTRL -- requirements
Module: siso_shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bits per parallel word, minimum 2.
REQ-002 Parameter DEPTH, default 4: stage count of the downstream serial-in/serial-out register, minimum 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data is offered.
REQ-007 in_ready  output  1  a word is accepted on the rising edge where in_valid and in_ready are both 1.
REQ-008 msb_first  input  1  bit order; sampled only at word acceptance.
REQ-009 ser_in  output  1  registered serial bit driven to the shift register input.
REQ-010 q_valid  output  1  the shift register Q currently carries a valid data bit.
REQ-011 word_done  output  1  one-cycle pulse while the last bit of a word is on Q.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The states SHALL be IDLE, SHIFT and FLUSH.
REQ-014 in_ready SHALL be 1 in IDLE, in FLUSH, and in the last bit cycle of SHIFT; it SHALL be 0 otherwise.
REQ-015 On acceptance the block SHALL latch in_data and msb_first, load bit_cnt to WIDTH-1 and enter SHIFT.
REQ-016 In SHIFT, ser_in SHALL present one bit per cycle in the latched order: bit 0 first when msb_first=0, bit WIDTH-1 first when msb_first=1.
REQ-017 The first bit SHALL appear on ser_in in the cycle after the acceptance edge.
REQ-018 In SHIFT, bit_cnt SHALL decrement each cycle.
REQ-019 At bit_cnt=0 in SHIFT, an acceptance SHALL reload the word and stay in SHIFT with no idle cycle; without an acceptance the block SHALL enter FLUSH.
REQ-020 Outside SHIFT, ser_in SHALL be 0.
REQ-021 A DEPTH-deep valid shadow pipeline SHALL be maintained, with its input 1 exactly when ser_in carries data. q_valid SHALL be its last stage, so a bit on ser_in in cycle c has q_valid=1 in cycle c+DEPTH.
REQ-022 A parallel DEPTH-deep last-bit flag pipeline SHALL track each word's final bit. word_done SHALL be its last stage ANDed with q_valid.
REQ-023 FLUSH SHALL return to IDLE when the shadow pipeline holds no valid bit; an acceptance in FLUSH SHALL enter SHIFT directly.
REQ-024 In FLUSH, the shadow pipeline SHALL continue to drain while a new word starts shifting.
REQ-025 in_valid without in_ready SHALL have no effect; in_data need not stay stable.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter IDLE and clear bit_cnt, the data latch, and both shadow pipelines.
REQ-027 In the cycle after that edge, ser_in, q_valid, word_done and busy SHALL be 0 and in_ready SHALL be 1.
REQ-028 A reset during SHIFT or FLUSH SHALL discard all in-flight bits and produce no word_done pulse.

Structure
REQ-029 A shared package siso_pkg SHALL hold the state enum type and the default WIDTH and DEPTH constants.
REQ-030 bit_cnt width SHALL be $clog2(WIDTH) bits.
REQ-031 The valid and last-bit shadow pipelines SHALL be one sub-module, siso_track_pipe, parameterized by DEPTH.

Verification (WIDTH=8, DEPTH=4; the acceptance edge ends cycle 0)
REQ-032 Reset check: hold rst=1 for 2 cycles -> in_ready=1 and busy, ser_in, q_valid, word_done all 0.
REQ-033 Single word: 0xA5 with msb_first=0 -> ser_in=1,0,1,0,0,1,0,1 in cycles 1-8; q_valid=1 in cycles 5-12; word_done=1 only in cycle 12; busy=0 from cycle 13.
REQ-034 Back-to-back: 0x01 then 0x80, both msb_first=1, second accepted in cycle 8 -> ser_in=1 only in cycles 8 and 9 over cycles 1-16; word_done in cycles 12 and 20.
REQ-035 Stall: in_valid held high from cycle 0 -> in_ready=0 in cycles 1-7 and 1 in cycle 8, so exactly one word is accepted per 8 cycles.
REQ-036 Mid-operation reset: rst=1 at the edge ending cycle 3 -> from cycle 4 ser_in=0, q_valid=0, busy=0 and in_ready=1; no word_done pulse afterwards.
REQ-037 FLUSH restart: second word accepted in cycle 10 -> q_valid stays 1 for first-word bits through cycle 12, then goes to 1 again from cycle 15.
